zap_mult_seq: RTL and testbench

ZAP_MULT_SEQ -- requirements
Module: zap_mult_seq

---
 rtl/zap_mult_seq_pkg.sv | 32 +++
 rtl/zap_mult_8x32.sv | 26 ++
 rtl/zap_mult_seq.sv | 215 +++++++++++++++++++++
 tb/tb_zap_mult_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_mult_seq_pkg.sv
// zap_mult_seq_pkg
//   Shared definitions for the sequential multiplier: FSM state encoding,
//   iteration count of the byte-serial multiply loop and the operand
//   magnitude helper used when latching signed operands.
package zap_mult_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_FIX  = 3'd2,
    ST_DONE = 3'd3,
    ST_HOLD = 3'd4
  } state_e;

  // One multiplier byte is consumed per MUL cycle.
  localparam int unsigned MUL_ITERS = 4;
  localparam int unsigned CNT_W     = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

  // Magnitude of a 32-bit operand. 0x80000000 maps onto itself, which is the
  // correct unsigned magnitude of -2^31.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    logic [31:0] r;
    if (is_signed && v[31]) begin
      r = ~v + 32'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/zap_mult_8x32.sv
// zap_mult_8x32
//   Combinational 8x32 partial-product generator for the byte-serial
//   multiplier loop.
//   Ports:
//     i_a  [7:0]   multiplier byte
//     i_b  [31:0]  multiplicand magnitude
//     o_p  [39:0]  unsigned product i_a * i_b
module zap_mult_8x32 (
  input  logic [7:0]  i_a,
  input  logic [31:0] i_b,
  output logic [39:0] o_p
);

  // Shift-and-add over the eight multiplier bits.
  always_comb begin
    o_p = 40'd0;
    for (int i = 0; i < 8; i++) begin
      if (i_a[i]) begin
        o_p = o_p + ({8'd0, i_b} << i);
      end else begin
        o_p = o_p;
      end
    end
  end

endmodule

// File: rtl/zap_mult_seq.sv
// zap_mult_seq
//   Sequential 32x32 multiplier / multiply-accumulate unit. Operands are
//   converted to magnitudes, multiplied one multiplier byte per cycle, then
//   sign-corrected and accumulated. Long multiplies cache the high word so
//   the following hi-phase micro-op completes in a single cycle.
//   Ports:
//     i_clk, i_reset_n        clock, asynchronous active-low reset
//     i_start, i_hi_phase     micro-op valid; micro-op is the high-word half
//     i_long, i_signed        64-bit product; two's complement operands
//     i_accumulate            add {i_acc_hi,i_acc_lo} (or i_acc_lo if short)
//     i_rm, i_rs              multiplicand, multiplier
//     i_stall, i_clear        freeze all state; flush (wins over stall)
//     o_busy                  stall request to earlier stages
//     o_valid, o_result       one-cycle result pulse and result word
module zap_mult_seq
  import zap_mult_seq_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic        i_hi_phase,
  input  logic        i_long,
  input  logic        i_signed,
  input  logic        i_accumulate,
  input  logic [31:0] i_rm,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_acc_lo,
  input  logic [31:0] i_acc_hi,
  input  logic        i_stall,
  input  logic        i_clear,
  output logic        o_busy,
  output logic        o_valid,
  output logic [31:0] o_result
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      prod_q, prod_d;
  logic [63:0]      acc_q, acc_d;
  logic [31:0]      rm_q, rm_d;
  logic [31:0]      rs_q, rs_d;
  logic [31:0]      result_q, result_d;
  logic             sign_q, sign_d;
  logic             long_q, long_d;
  logic             hi_only_q, hi_only_d;
  logic             valid_q, valid_d;

  logic [7:0]       rs_byte_s;
  logic [39:0]      pp_s;
  logic [63:0]      fixed_s;
  logic             start_new_s;
  logic             load_s;

  // A full operation is accepted from IDLE (either phase) or from HOLD when
  // the incoming micro-op is not the hi half of the cached result.
  assign start_new_s = i_start & ((state_q == ST_IDLE) |
                                  ((state_q == ST_HOLD) & ~i_hi_phase));

  assign o_busy   = i_reset_n & ((state_q == ST_MUL) | (state_q == ST_FIX) | start_new_s);
  assign o_valid  = valid_q;
  assign o_result = result_q;

  // Select the multiplier byte for the current iteration.
  always_comb begin
    case (cnt_q)
      2'd0:    rs_byte_s = rs_q[7:0];
      2'd1:    rs_byte_s = rs_q[15:8];
      2'd2:    rs_byte_s = rs_q[23:16];
      2'd3:    rs_byte_s = rs_q[31:24];
      default: rs_byte_s = 8'd0;
    endcase
  end

  zap_mult_8x32 u_pp (
    .i_a (rs_byte_s),
    .i_b (rm_q),
    .o_p (pp_s)
  );

  // Sign correction of the magnitude product followed by accumulation.
  always_comb begin
    if (sign_q) begin
      fixed_s = (~prod_q + 64'd1) + acc_q;
    end else begin
      fixed_s = prod_q + acc_q;
    end
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    acc_d     = acc_q;
    rm_d      = rm_q;
    rs_d      = rs_q;
    sign_d    = sign_q;
    long_d    = long_q;
    hi_only_d = hi_only_q;
    valid_d   = 1'b0;
    result_d  = 32'd0;
    load_s    = 1'b0;

    if (i_clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (i_stall) begin
      // Everything freezes; a DONE pulse is stretched until the stall drops.
      if (state_q == ST_DONE) begin
        valid_d  = valid_q;
        result_d = result_q;
      end else begin
        valid_d  = 1'b0;
        result_d = 32'd0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            load_s  = 1'b1;
            state_d = ST_MUL;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_MUL: begin
          prod_d = prod_q + ({24'd0, pp_s} << {cnt_q, 3'b000});
          if (cnt_q == CNT_LAST) begin
            state_d = ST_FIX;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
        ST_FIX: begin
          prod_d   = fixed_s;
          valid_d  = 1'b1;
          result_d = hi_only_q ? fixed_s[63:32] : fixed_s[31:0];
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          // A hi-phase op that ran the full sequence has nothing left to cache.
          if (long_q && !hi_only_q) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (i_start && i_hi_phase) begin
            valid_d  = 1'b1;
            result_d = prod_q[63:32];
            state_d  = ST_IDLE;
          end else if (i_start) begin
            load_s  = 1'b1;
            state_d = ST_MUL;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (load_s) begin
      rm_d      = mag32(i_rm, i_signed);
      rs_d      = mag32(i_rs, i_signed);
      sign_d    = i_signed & (i_rm[31] ^ i_rs[31]);
      long_d    = i_long;
      hi_only_d = i_hi_phase;
      prod_d    = 64'd0;
      cnt_d     = '0;
      if (!i_accumulate) begin
        acc_d = 64'd0;
      end else if (i_long) begin
        acc_d = {i_acc_hi, i_acc_lo};
      end else begin
        acc_d = {32'd0, i_acc_lo};
      end
    end else begin
      load_s = 1'b0;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      prod_q    <= 64'd0;
      acc_q     <= 64'd0;
      rm_q      <= 32'd0;
      rs_q      <= 32'd0;
      sign_q    <= 1'b0;
      long_q    <= 1'b0;
      hi_only_q <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      acc_q     <= acc_d;
      rm_q      <= rm_d;
      rs_q      <= rs_d;
      sign_q    <= sign_d;
      long_q    <= long_d;
      hi_only_q <= hi_only_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_zap_mult_seq.sv
// tb_zap_mult_seq
//   Self-checking bench for zap_mult_seq. Expected result words are pushed
//   to a scoreboard queue when an op is driven and popped when o_valid fires.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_zap_mult_seq;
  import zap_mult_seq_pkg::*;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_start;
  logic        i_hi_phase;
  logic        i_long;
  logic        i_signed;
  logic        i_accumulate;
  logic [31:0] i_rm;
  logic [31:0] i_rs;
  logic [31:0] i_acc_lo;
  logic [31:0] i_acc_hi;
  logic        i_stall;
  logic        i_clear;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;

  int          total;
  int          bad;
  logic [31:0] exp_q[$];

  zap_mult_seq dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_start      (i_start),
    .i_hi_phase   (i_hi_phase),
    .i_long       (i_long),
    .i_signed     (i_signed),
    .i_accumulate (i_accumulate),
    .i_rm         (i_rm),
    .i_rs         (i_rs),
    .i_acc_lo     (i_acc_lo),
    .i_acc_hi     (i_acc_hi),
    .i_stall      (i_stall),
    .i_clear      (i_clear),
    .o_busy       (o_busy),
    .o_valid      (o_valid),
    .o_result     (o_result)
  );

  always #5 i_clk = ~i_clk;

  // Reference: full-width product of extended operands, plus accumulator.
  function automatic logic [63:0] model(input logic [31:0] rm, input logic [31:0] rs,
                                        input logic lng, input logic sgn, input logic acc,
                                        input logic [31:0] alo, input logic [31:0] ahi);
    logic [63:0] a, b, p;
    a = sgn ? {{32{rm[31]}}, rm} : {32'd0, rm};
    b = sgn ? {{32{rs[31]}}, rs} : {32'd0, rs};
    p = a * b;
    if (acc) p = p + (lng ? {ahi, alo} : {32'd0, alo});
    return p;
  endfunction

  task automatic drive_op(input logic [31:0] rm, input logic [31:0] rs, input logic lng,
                          input logic sgn, input logic acc, input logic hi,
                          input logic [31:0] alo, input logic [31:0] ahi);
    i_start = 1'b1; i_hi_phase = hi; i_long = lng; i_signed = sgn; i_accumulate = acc;
    i_rm = rm; i_rs = rs; i_acc_lo = alo; i_acc_hi = ahi;
  endtask

  task automatic drive_hi();
    i_start = 1'b1; i_hi_phase = 1'b1;
  endtask

  task automatic pop_exp(output logic [31:0] w);
    if (exp_q.size() != 0) w = exp_q.pop_front();
    else w = 32'hDEAD_0000;
  endtask

  // Counts falling edges until o_valid; lat = -1 if the budget expires.
  task automatic wait_valid(input int max_cyc, output int lat);
    lat = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge i_clk);
      if (i == 1) i_start = 1'b0;
      if (o_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    total++; if (o_result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", o_result); end
    i_start = 1'b1;
    #1;
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", o_busy); end
    i_start = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state_q, ST_IDLE); end
  endtask

  // Long op: low word at latency 6, then hi-phase from HOLD at latency 1.
  task automatic run_long(input string nm, input logic [31:0] rm, input logic [31:0] rs,
                          input logic sgn, input logic acc, input logic [31:0] alo,
                          input logic [31:0] ahi);
    logic [63:0] p;
    logic [31:0] want;
    int lat;
    p = model(rm, rs, 1'b1, sgn, acc, alo, ahi);
    exp_q.push_back(p[31:0]);
    drive_op(rm, rs, 1'b1, sgn, acc, 1'b0, alo, ahi);
    #1;
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL %s_busy_accept got=%b want=1", nm, o_busy); end
    wait_valid(20, lat);
    total++; if (lat !== 6) begin bad++; $display("FAIL %s_lat_lo got=%0d want=6", nm, lat); end
    pop_exp(want);
    total++; if (o_result !== want) begin bad++; $display("FAIL %s_lo got=%h want=%h", nm, o_result, want); end
    @(negedge i_clk);
    total++; if ({o_valid, o_busy} !== 2'b00) begin bad++; $display("FAIL %s_hold got=%b want=00", nm, {o_valid, o_busy}); end
    exp_q.push_back(p[63:32]);
    drive_hi();
    wait_valid(4, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL %s_lat_hi got=%0d want=1", nm, lat); end
    pop_exp(want);
    total++; if (o_result !== want) begin bad++; $display("FAIL %s_hi got=%h want=%h", nm, o_result, want); end
    i_hi_phase = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_umull();
    run_long("umull", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_smull();
    run_long("smull", 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_umlal();
    run_long("umlal", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000);
  endtask

  task automatic test_short();
    logic [31:0] want;
    int lat;
    exp_q.push_back(32'h0000_002A);
    drive_op(32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_valid(20, lat);
    total++; if (lat !== 6) begin bad++; $display("FAIL short_lat got=%0d want=6", lat); end
    pop_exp(want);
    total++; if (o_result !== want) begin bad++; $display("FAIL short_res got=%h want=%h", o_result, want); end
    @(negedge i_clk);
    total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL short_no_hold got=%0d want=%0d", dut.state_q, ST_IDLE); end
    total++; if (o_result !== 32'd0) begin bad++; $display("FAIL short_res_idle got=%h want=0", o_result); end
  endtask

  task automatic test_clear();
    logic [31:0] want;
    int lat;
    int seen;
    drive_op(32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    #1;
    total++; if ({o_busy, o_valid} !== 2'b00) begin bad++; $display("FAIL clear_busy_valid got=%b want=00", {o_busy, o_valid}); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      if (o_valid !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL clear_no_valid got=%0d want=0", seen); end
    exp_q.push_back(32'h0000_0009);
    drive_op(32'd3, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_valid(20, lat);
    total++; if (lat !== 6) begin bad++; $display("FAIL clear_next_lat got=%0d want=6", lat); end
    pop_exp(want);
    total++; if (o_result !== want) begin bad++; $display("FAIL clear_next_res got=%h want=%h", o_result, want); end
    @(negedge i_clk);
  endtask

  task automatic test_stall();
    logic [63:0] p;
    logic [31:0] want;
    int lat;
    p = model(32'h89AB_CDEF, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0001);
    exp_q.push_back(p[31:0]);
    drive_op(32'h89AB_CDEF, 32'h1234_5678, 1'b1, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0001);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge i_clk);
      if (i == 1) begin i_start = 1'b0; i_stall = 1'b1; end
      if (i == 3) i_stall = 1'b0;
      if (o_valid === 1'b1) begin lat = i; break; end
    end
    total++; if (lat !== 8) begin bad++; $display("FAIL stall_lat got=%0d want=8", lat); end
    pop_exp(want);
    total++; if (o_result !== want) begin bad++; $display("FAIL stall_lo got=%h want=%h", o_result, want); end
    i_stall = 1'b1;
    @(negedge i_clk);
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL stall_valid_held got=%b want=1", o_valid); end
    total++; if (o_result !== p[31:0]) begin bad++; $display("FAIL stall_res_held got=%h want=%h", o_result, p[31:0]); end
    i_stall = 1'b0;
    @(negedge i_clk);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL stall_valid_drop got=%b want=0", o_valid); end
    exp_q.push_back(p[63:32]);
    drive_hi();
    i_stall = 1'b1;
    @(negedge i_clk);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL stall_hold_frozen got=%b want=0", o_valid); end
    i_stall = 1'b0;
    wait_valid(4, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL stall_lat_hi got=%0d want=1", lat); end
    pop_exp(want);
    total++; if (o_result !== want) begin bad++; $display("FAIL stall_hi got=%h want=%h", o_result, want); end
    i_hi_phase = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_random();
    logic [31:0] rm, rs, alo, ahi, want;
    logic sgn, acc, lng;
    logic [63:0] p;
    int lat;
    for (int n = 0; n < 8; n++) begin
      rm = $urandom; rs = $urandom; alo = $urandom; ahi = $urandom;
      sgn = 1'($urandom_range(0, 1)); acc = 1'($urandom_range(0, 1));
      lng = 1'($urandom_range(0, 1));
      if (lng) begin
        run_long("rand_long", rm, rs, sgn, acc, alo, ahi);
      end else begin
        p = model(rm, rs, 1'b0, sgn, acc, alo, ahi);
        exp_q.push_back(p[31:0]);
        drive_op(rm, rs, 1'b0, sgn, acc, 1'b0, alo, ahi);
        wait_valid(20, lat);
        total++; if (lat !== 6) begin bad++; $display("FAIL rand_short_lat got=%0d want=6", lat); end
        pop_exp(want);
        total++; if (o_result !== want) begin bad++; $display("FAIL rand_short got=%h want=%h", o_result, want); end
        @(negedge i_clk);
      end
    end
  endtask

  task automatic test_reset_fix();
    logic [31:0] want;
    int lat;
    drive_op(32'h8000_0001, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge i_clk);
      if (i == 1) i_start = 1'b0;
    end
    total++; if (dut.state_q !== ST_FIX) begin bad++; $display("FAIL rstfix_in_fix got=%0d want=%0d", dut.state_q, ST_FIX); end
    #2;
    i_reset_n = 1'b0;
    #1;
    total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL rstfix_state got=%0d want=%0d", dut.state_q, ST_IDLE); end
    total++; if ({o_valid, o_busy, o_result} !== 34'd0) begin bad++; $display("FAIL rstfix_outputs got=%h want=0", {o_valid, o_busy, o_result}); end
    total++; if (dut.prod_q !== 64'd0) begin bad++; $display("FAIL rstfix_prod got=%h want=0", dut.prod_q); end
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    exp_q.push_back(32'h0000_0001);
    drive_op(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    wait_valid(20, lat);
    total++; if (lat !== 6) begin bad++; $display("FAIL rstfix_hi_full_lat got=%0d want=6", lat); end
    pop_exp(want);
    total++; if (o_result !== want) begin bad++; $display("FAIL rstfix_hi_full got=%h want=%h", o_result, want); end
    i_hi_phase = 1'b0;
    @(negedge i_clk);
    total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL rstfix_back_idle got=%0d want=%0d", dut.state_q, ST_IDLE); end
  endtask

  initial begin
    total = 0; bad = 0;
    i_clk = 1'b0; i_reset_n = 1'b0;
    i_start = 1'b0; i_hi_phase = 1'b0; i_long = 1'b0; i_signed = 1'b0;
    i_accumulate = 1'b0; i_rm = 32'd0; i_rs = 32'd0; i_acc_lo = 32'd0;
    i_acc_hi = 32'd0; i_stall = 1'b0; i_clear = 1'b0;
    test_reset();
    test_umull();
    test_smull();
    test_short();
    test_umlal();
    test_clear();
    test_stall();
    test_random();
    test_reset_fix();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
